// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg
//   Definitions shared by the step monitor and its classifier:
//   - bit positions inside the one-hot status word
//   - FSM state encoding
//   - run direction enum

package seq_mon_pkg;

    // Bit positions inside status[3:0] = {error, hold, decr, incr}
    localparam int ST_INCR = 0;
    localparam int ST_DECR = 1;
    localparam int ST_HOLD = 2;
    localparam int ST_ERR  = 3;

    // FSM state encoding
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

endpackage

// File: rtl/seq_step_monitor_classifier.sv
// step_classifier
//   Purely combinational. Compares a new sample against the previous one and
//   returns the one-hot class {error, hold, decr, incr}.
// Ports:
//   prev_i   : previous accepted sample
//   in_val_i : new sample
//   class_o  : one-hot class, bit positions from seq_mon_pkg

module step_classifier
    import seq_mon_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_STEP = 1,
    parameter int WRAP_EN  = 0
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] in_val_i,
    output logic [3:0]       class_o
);

    localparam logic [WIDTH-1:0] STEP_MAX = WIDTH'(MAX_STEP);

    logic [WIDTH-1:0] up_diff;
    logic [WIDTH-1:0] dn_diff;
    logic             up_ok;
    logic             dn_ok;

    // Modular differences in both directions. Because MAX_STEP is below half
    // the range, at most one of them can be in 1..MAX_STEP. Without wrap the
    // plain ordering must additionally agree with the direction, which rules
    // out max->0 and 0->max.
    always_comb begin
        up_diff = in_val_i - prev_i;
        dn_diff = prev_i - in_val_i;
        up_ok   = (up_diff != '0) && (up_diff <= STEP_MAX);
        dn_ok   = (dn_diff != '0) && (dn_diff <= STEP_MAX);
        if (WRAP_EN == 0) begin
            up_ok = up_ok && (in_val_i > prev_i);
            dn_ok = dn_ok && (in_val_i < prev_i);
        end

        class_o = '0;
        if (in_val_i == prev_i) begin
            class_o[ST_HOLD] = 1'b1;
        end else if (up_ok) begin
            class_o[ST_INCR] = 1'b1;
        end else if (dn_ok) begin
            class_o[ST_DECR] = 1'b1;
        end else begin
            class_o[ST_ERR] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_step_monitor.sv
// seq_step_monitor
//   Classifies each sampled counter value against the previous one
//   (incr/decr/hold/error), counts errors, tracks same-direction run length
//   and latches a fault after ERR_LIMIT consecutive errors.
// Ports:
//   clk, rst, clr : clock, synchronous reset, synchronous soft clear
//   in_valid      : in_val is presented this cycle
//   in_val        : sampled counter value
//   out_valid     : one-cycle pulse, status valid
//   status        : one-hot {error, hold, decr, incr}, zero when idle
//   err_count     : saturating total error count
//   run_len       : saturating same-direction run length
//   fault         : high while latched in FAULT
//
// state   | meaning
// --------+-----------------------------------------------------------
// EMPTY   | no reference sample yet; next accepted sample is stored only
// TRACK   | classifying every accepted sample against prev
// FAULT   | ERR_LIMIT consecutive errors seen; inputs ignored until clear

module seq_step_monitor
    import seq_mon_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_STEP  = 1,
    parameter int WRAP_EN   = 0,
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_val,
    output logic             out_valid,
    output logic [3:0]       status,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] run_len,
    output logic             fault
);

    localparam int CE_W = $clog2(ERR_LIMIT + 1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] prev_q,      prev_d;
    dir_e             dir_q,       dir_d;
    logic [CE_W-1:0]  consec_q,    consec_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] run_q,       run_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       status_q,    status_d;
    logic [3:0]       cls;

    step_classifier #(
        .WIDTH    (WIDTH),
        .MAX_STEP (MAX_STEP),
        .WRAP_EN  (WRAP_EN)
    ) u_classifier (
        .prev_i   (prev_q),
        .in_val_i (in_val),
        .class_o  (cls)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dir_d       = dir_q;
        consec_d    = consec_q;
        err_cnt_d   = err_cnt_q;
        run_d       = run_q;
        out_valid_d = 1'b0;
        status_d    = '0;

        case (state_q)
            S_EMPTY: begin
                if (in_valid) begin
                    prev_d  = in_val;
                    state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                if (in_valid) begin
                    out_valid_d = 1'b1;
                    status_d    = cls;
                    prev_d      = in_val;
                    if (cls[ST_ERR]) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                        consec_d = consec_q + CE_W'(1);
                        run_d    = '0;
                        // The limiting error is still reported this cycle.
                        if (consec_d == CE_W'(ERR_LIMIT)) state_d = S_FAULT;
                    end else begin
                        consec_d = '0;
                        if (cls[ST_INCR]) begin
                            if (dir_q == DIR_UP) begin
                                if (run_q != '1) run_d = run_q + CNT_W'(1);
                            end else begin
                                run_d = CNT_W'(1);
                            end
                            dir_d = DIR_UP;
                        end else if (cls[ST_DECR]) begin
                            if (dir_q == DIR_DOWN) begin
                                if (run_q != '1) run_d = run_q + CNT_W'(1);
                            end else begin
                                run_d = CNT_W'(1);
                            end
                            dir_d = DIR_DOWN;
                        end
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // rst and clr share one clear path; either one discards a same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= S_EMPTY;
            prev_q      <= '0;
            dir_q       <= DIR_NONE;
            consec_q    <= '0;
            err_cnt_q   <= '0;
            run_q       <= '0;
            out_valid_q <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            dir_q       <= dir_d;
            consec_q    <= consec_d;
            err_cnt_q   <= err_cnt_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            status_q    <= status_d;
        end
    end

    assign out_valid = out_valid_q;
    assign status    = status_q;
    assign err_count = err_cnt_q;
    assign run_len   = run_q;
    assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_seq_step_monitor.sv
module tb_seq_step_monitor;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] INCR = 4'b0001;
    localparam logic [3:0] DECR = 4'b0010;
    localparam logic [3:0] HOLD = 4'b0100;
    localparam logic [3:0] ERR  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_val = '0;

    // d_: defaults, w_: WRAP_EN=1, m_: MAX_STEP=2, s_: CNT_W=2 ERR_LIMIT=8
    logic       d_ov, w_ov, m_ov, s_ov;
    logic [3:0] d_st, w_st, m_st, s_st;
    logic [7:0] d_err, w_err, m_err;
    logic [7:0] d_run, w_run, m_run;
    logic [1:0] s_err, s_run;
    logic       d_flt, w_flt, m_flt, s_flt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    seq_step_monitor u_def (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_val(in_val),
        .out_valid(d_ov), .status(d_st), .err_count(d_err), .run_len(d_run), .fault(d_flt));

    seq_step_monitor #(.WRAP_EN(1)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_val(in_val),
        .out_valid(w_ov), .status(w_st), .err_count(w_err), .run_len(w_run), .fault(w_flt));

    seq_step_monitor #(.MAX_STEP(2)) u_ms2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_val(in_val),
        .out_valid(m_ov), .status(m_st), .err_count(m_err), .run_len(m_run), .fault(m_flt));

    seq_step_monitor #(.CNT_W(2), .ERR_LIMIT(8)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_val(in_val),
        .out_valid(s_ov), .status(s_st), .err_count(s_err), .run_len(s_run), .fault(s_flt));

    task automatic check_eq(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Presents one sample for one edge; outputs are then the result for it.
    task automatic send(input logic [3:0] v);
        in_valid = 1'b1;
        in_val   = v;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t1_val [8] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5};
    logic [3:0] t1_exp [8] = '{NONE, HOLD, INCR, INCR, INCR, INCR, HOLD, INCR};
    logic [3:0] t6_val [6] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9};
    int         t6_err [6] = '{0, 1, 2, 3, 3, 3};

    initial begin
        // reset state
        do_reset();
        check_eq("rst_ov",    d_ov,  0);
        check_eq("rst_st",    d_st,  0);
        check_eq("rst_err",   d_err, 0);
        check_eq("rst_run",   d_run, 0);
        check_eq("rst_fault", d_flt, 0);

        // 1: basic hold/incr sequence
        for (int i = 0; i < 8; i++) begin
            send(t1_val[i]);
            check_eq($sformatf("t1_ov%0d", i), d_ov, (t1_exp[i] != NONE) ? 1 : 0);
            check_eq($sformatf("t1_st%0d", i), d_st, t1_exp[i]);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("t1_idle_ov", d_ov, 0);
        check_eq("t1_idle_st", d_st, 0);
        check_eq("t1_run", d_run, 5);
        check_eq("t1_err", d_err, 0);

        // 2: wrap boundary, no-wrap vs wrap
        do_reset();
        send(4'd14);
        check_eq("t2_prime", d_ov, 0);
        send(4'd15);
        check_eq("t2_d_st1", d_st, INCR);
        check_eq("t2_w_st1", w_st, INCR);
        send(4'd0);
        check_eq("t2_d_st2", d_st, ERR);
        check_eq("t2_w_st2", w_st, INCR);
        check_eq("t2_d_err", d_err, 1);
        check_eq("t2_d_run", d_run, 0);
        check_eq("t2_w_run", w_run, 2);
        send(4'd15);
        check_eq("t2_d_st3", d_st, ERR);
        check_eq("t2_w_st3", w_st, DECR);
        check_eq("t2_d_err3", d_err, 2);
        check_eq("t2_w_run3", w_run, 1);
        check_eq("t2_d_fault", d_flt, 0);

        // 3: MAX_STEP=2
        do_reset();
        send(4'd5);
        send(4'd7);
        check_eq("t3_st1", m_st, INCR);
        check_eq("t3_run1", m_run, 1);
        send(4'd4);
        check_eq("t3_st2", m_st, ERR);
        send(4'd2);
        check_eq("t3_st3", m_st, DECR);
        check_eq("t3_run3", m_run, 1);
        check_eq("t3_err", m_err, 1);

        // 4: three consecutive errors latch FAULT
        do_reset();
        send(4'd0);
        send(4'd5);
        check_eq("t4_st1", d_st, ERR);
        check_eq("t4_flt1", d_flt, 0);
        send(4'd10);
        check_eq("t4_st2", d_st, ERR);
        check_eq("t4_flt2", d_flt, 0);
        send(4'd15);
        check_eq("t4_st3", d_st, ERR);
        check_eq("t4_ov3", d_ov, 1);
        check_eq("t4_flt3", d_flt, 1);
        send(4'd1);
        check_eq("t4_ov4", d_ov, 0);
        check_eq("t4_st4", d_st, 0);
        check_eq("t4_err", d_err, 3);
        check_eq("t4_flt4", d_flt, 1);

        // 5: clr with in_valid while in FAULT
        clr = 1'b1;
        send(4'd3);
        clr = 1'b0;
        check_eq("t5_flt", d_flt, 0);
        check_eq("t5_err", d_err, 0);
        check_eq("t5_ov", d_ov, 0);
        send(4'd4);
        check_eq("t5_prime_ov", d_ov, 0);
        send(4'd5);
        check_eq("t5_st", d_st, INCR);
        check_eq("t5_run", d_run, 1);

        // 6: error counter saturates at 3 with CNT_W=2
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(t6_val[i]);
            if (i > 0) check_eq($sformatf("t6_st%0d", i), s_st, ERR);
            check_eq($sformatf("t6_err%0d", i), s_err, t6_err[i]);
        end
        check_eq("t6_flt", s_flt, 0);

        // rst beats a same-cycle sample mid-run
        rst = 1'b1;
        send(4'd7);
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("t7_ov", s_ov, 0);
        check_eq("t7_err", s_err, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/seq_step_monitor.md
Name: seq_step_monitor

Overview:
- Parametrised successor to the 4-bit increment/decrement/error checker used in the taxi fare/odometer path.
- Watches a WIDTH-bit counter value sampled on in_valid and classifies each new sample against the previous one as incr, decr, hold or error.
- Adds a configurable step tolerance, optional modular wrap-around, a saturating error counter, a same-direction run-length counter, and a latched fault state after ERR_LIMIT consecutive errors.
- Sits between the odometer/fare counter and the status/alarm logic.

Parameters:
- WIDTH, 4: bit width of the monitored value.
- MAX_STEP, 1: largest legal step magnitude. Must satisfy 1 <= MAX_STEP < 2^(WIDTH-1).
- WRAP_EN, 0: 1 = differences are taken modulo 2^WIDTH, so max->0 counts as incr. 0 = plain unsigned difference, so a wrap is an error.
- ERR_LIMIT, 3: number of consecutive errors that forces the FAULT state (>=1).
- CNT_W, 8: width of err_count and run_len.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous soft clear; same effect as rst.
- in_valid  in  1  in_val is presented this cycle.
- in_val  in  WIDTH  sampled counter value.
- out_valid  out  1  one-cycle pulse; status is valid this cycle.
- status  out  4  one-hot {error, hold, decr, incr}; 0000 whenever out_valid=0.
- err_count  out  CNT_W  total errors since reset/clr; saturates at all-ones.
- run_len  out  CNT_W  length of the current same-direction run; saturating.
- fault  out  1  high while the block is in FAULT.

Behaviour:
- Reset values (rst or clr): state=EMPTY, out_valid=0, status=0000, err_count=0, run_len=0, fault=0, prev=0, consec_err=0.
- States and transitions:
  - EMPTY: the first accepted sample is stored in prev. No out_valid. Go to TRACK.
  - TRACK: each accepted sample is classified, then prev is updated to in_val (also on error).
  - FAULT: in_valid is ignored, prev is frozen, fault=1. Only rst or clr exits FAULT.
- Classification, with d = in_val - prev:
  - Width is WIDTH bits modulo 2^WIDTH if WRAP_EN=1; otherwise WIDTH+1-bit signed.
  - hold: d == 0.
  - incr: 1 <= d <= MAX_STEP. With WRAP_EN=1 this is modular d.
  - decr: 1 <= -d <= MAX_STEP. With WRAP_EN=1 this is 2^WIDTH - d.
  - error: anything else.
- Latency: sample at edge N produces out_valid and status registered at edge N+1. Back-to-back in_valid gives one result per cycle.
- run_len update:
  - incr/decr in the same direction as the last direction: +1.
  - Opposite direction, or the first direction after EMPTY: set to 1.
  - hold: unchanged.
  - error: 0.
- Counter updates:
  - err_count: +1 on each error, saturating.
  - consec_err: +1 on error, 0 on any non-error.
  - When an error makes consec_err == ERR_LIMIT, that error is still reported and the state goes to FAULT on the same edge.
- Simultaneous events:
  - rst beats clr; clr beats in_valid. The sample is discarded and no out_valid is produced.
- Boundaries:
  - WRAP_EN=0: max->0 and 0->max are error.
  - Values at 0 or all-ones have no special handling beyond the classification above.
- Reset mid-run: partially built run_len and err_count are discarded. The next sample re-primes EMPTY.

Decomposition:
- Shared package seq_mon_pkg holds:
  - Status bit index localparams: ST_INCR=0, ST_DECR=1, ST_HOLD=2, ST_ERR=3.
  - State encoding: EMPTY, TRACK, FAULT.
  - Direction enum: NONE, UP, DOWN.
- One sub-module, step_classifier: combinational. Takes prev, in_val, WIDTH, MAX_STEP, WRAP_EN and returns the one-hot class.
- The top level owns the FSM, counters and output registers.

Test Plan:
1. Defaults, rst for 2 cycles. Samples 0,0,1,2,3,4,4,5 -> first sample gives no out_valid, then hold,incr,incr,incr,incr,hold,incr. run_len ends at 5, err_count=0.
2. WRAP_EN=0, samples 14,15,0 -> incr then error. err_count=1, run_len=0. Rerun with WRAP_EN=1 -> incr,incr, run_len=2.
3. MAX_STEP=2, samples 5,7,4,2 -> incr, error (step 3), decr. run_len=1 after the decr.
4. ERR_LIMIT=3, samples 0,5,10,15,1 -> three errors, fault=1 on the third result edge. Sample 1 gives no out_valid. err_count=3.
5. clr asserted together with in_valid while in FAULT -> next cycle fault=0, err_count=0, no out_valid. The next sample only primes.
6. Hold err_count near saturation (CNT_W=2, four errors with ERR_LIMIT=8) -> err_count stays 3 and does not wrap.
